mesh_port_arbiter: RTL and testbench

- Shares one router output link among NUM_REQ input FIFOs, round-robin, one packet per grant.
- Each requester presents a show-ahead FIFO head (pndng plus data, popped by this block).
- The block drives a one-entry output register with the codebase pndng/data_out/pop handshake toward the downstream FIFO or link.
- Instantiated once per output terminal of each mesh router node.

---
 rtl/mesh_arb_pkg.sv | 24 ++
 rtl/mesh_port_arbiter_if.sv | 27 ++
 rtl/mesh_port_arbiter_rr_pick.sv | 40 ++++
 rtl/mesh_port_arbiter.sv | 131 +++++++++++++
 tb/tb_mesh_port_arbiter.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/mesh_arb_pkg.sv
// Purpose: shared types, constants and helpers for the mesh port arbiter.
// Contents: FSM state enum, destination-field width, default broadcast ID,
//           header offset helper and index-width helper.
package mesh_arb_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam int unsigned DEST_W = 8;
    localparam logic [DEST_W-1:0] BROADCAST_DEFAULT = 8'hFF;

    // MSB of the destination field; the header sits at the top of the packet.
    function automatic int unsigned dest_msb(input int unsigned sz);
        return sz - 1;
    endfunction

    // Width of a requester index; never zero so single-requester builds stay legal.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? unsigned'($clog2(n)) : 1;
    endfunction

endpackage

// File: rtl/mesh_port_arbiter_if.sv
// Purpose: requester-side and downstream-side handshake bundle of the arbiter.
// Signals: req_pndng/req_data/req_pop (input FIFO heads and pops),
//          pndng/data_out/popin (output register handshake), pkt_cnt.
// Modports: master = arbiter, slave = FIFOs/downstream environment.
interface mesh_port_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned pckg_sz = 40,
    parameter int unsigned CNT_W   = 16
);
    logic [NUM_REQ-1:0]         req_pndng;
    logic [NUM_REQ*pckg_sz-1:0] req_data;
    logic [NUM_REQ-1:0]         req_pop;
    logic                       pndng;
    logic [pckg_sz-1:0]         data_out;
    logic                       popin;
    logic [CNT_W-1:0]           pkt_cnt;

    modport master (
        input  req_pndng, req_data, popin,
        output req_pop, pndng, data_out, pkt_cnt
    );

    modport slave (
        output req_pndng, req_data, popin,
        input  req_pop, pndng, data_out, pkt_cnt
    );
endinterface

// File: rtl/mesh_port_arbiter_rr_pick.sv
// Purpose: combinational round-robin search starting at ptr, wrapping.
// Ports: req (request vector), ptr (start index),
//        grant_c (one-hot winner), idx_c (winner index), any_c (|req).
module rr_pick
    import mesh_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant_c,
    output logic [IDX_W-1:0]   idx_c,
    output logic               any_c
);

    logic [NUM_REQ-1:0] upper_mask;
    logic [NUM_REQ-1:0] upper_req;
    logic [NUM_REQ-1:0] upper_first;
    logic [NUM_REQ-1:0] lower_first;

    // Requests at or above ptr win first; otherwise wrap to the lowest request.
    assign upper_mask  = ~((NUM_REQ'(1) << ptr) - NUM_REQ'(1));
    assign upper_req   = req & upper_mask;
    assign upper_first = upper_req & (~upper_req + NUM_REQ'(1));
    assign lower_first = req & (~req + NUM_REQ'(1));

    assign grant_c = (|upper_req) ? upper_first : lower_first;
    assign any_c   = |req;

    // One-hot to binary: index bit b is set when the grant hits a position with bit b set.
    for (genvar b = 0; b < IDX_W; b++) begin : g_idx
        logic [NUM_REQ-1:0] sel_mask;
        for (genvar g = 0; g < NUM_REQ; g++) begin : g_pos
            assign sel_mask[g] = ((g >> b) & 1) != 0;
        end
        assign idx_c[b] = |(grant_c & sel_mask);
    end

endmodule

// File: rtl/mesh_port_arbiter.sv
// Purpose: round-robin share of one mesh router output link among NUM_REQ
//          show-ahead input FIFOs, one packet per grant, one-entry output register.
// Ports: clk, reset (async, active-high), bus (mesh_port_arbiter_if.master):
//        req_pndng/req_data in, req_pop out (combinational),
//        pndng/data_out out, popin in, pkt_cnt out.
// Option: MESH_ARB_BCAST_PRIO_EN - heads whose destination equals broadcast
//         are searched first so broadcasts drain ahead of unicast traffic.
module mesh_port_arbiter
    import mesh_arb_pkg::*;
#(
    parameter int unsigned        NUM_REQ   = 4,
    parameter int unsigned        pckg_sz   = 40,
    parameter logic [DEST_W-1:0]  broadcast = BROADCAST_DEFAULT,
    parameter int unsigned        CNT_W     = 16
) (
    input logic                  clk,
    input logic                  reset,
    mesh_port_arbiter_if.master  bus
);

    localparam int unsigned IDX_W = idx_w(NUM_REQ);

`ifdef MESH_ARB_BCAST_PRIO_EN
    localparam bit PRIO_EN = 1'b1;
`else
    localparam bit PRIO_EN = 1'b0;
`endif

    state_t             state_q;
    state_t             state_d;
    logic               load_c;
    logic [IDX_W-1:0]   rr_ptr;
    logic [pckg_sz-1:0] data_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [pckg_sz-1:0] data_sel;

    logic [NUM_REQ-1:0] bc_req;
    logic [NUM_REQ-1:0] all_grant;
    logic [NUM_REQ-1:0] bc_grant;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   all_idx;
    logic [IDX_W-1:0]   bc_idx;
    logic [IDX_W-1:0]   pick_idx;
    logic               all_any;
    logic               bc_any;

    // Pending heads carrying the broadcast destination.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_bc
        assign bc_req[g] = bus.req_pndng[g] &&
            (bus.req_data[g*pckg_sz + dest_msb(pckg_sz) -: DEST_W] == broadcast);
    end

    rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick_all (
        .req     (bus.req_pndng),
        .ptr     (rr_ptr),
        .grant_c (all_grant),
        .idx_c   (all_idx),
        .any_c   (all_any)
    );

    rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick_bc (
        .req     (bc_req),
        .ptr     (rr_ptr),
        .grant_c (bc_grant),
        .idx_c   (bc_idx),
        .any_c   (bc_any)
    );

    // Restricted search wins only when enabled and a broadcast is waiting.
    assign grant    = (PRIO_EN && bc_any) ? bc_grant : all_grant;
    assign pick_idx = (PRIO_EN && bc_any) ? bc_idx   : all_idx;

    // Winner's head: per data bit, OR of grant with that bit of every head.
    for (genvar k = 0; k < pckg_sz; k++) begin : g_col
        logic [NUM_REQ-1:0] col;
        for (genvar g = 0; g < NUM_REQ; g++) begin : g_row
            assign col[g] = bus.req_data[g*pckg_sz + k];
        end
        assign data_sel[k] = |(grant & col);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a load always leaves the register full; a pop without refill empties it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (load_c) state_d = FULL;
            FULL:    if (!load_c && bus.popin) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // Outputs: refill whenever the register is free or being drained this cycle.
    always_comb begin
        load_c      = ((state_q == EMPTY) || bus.popin) && all_any;
        bus.req_pop = '0;
        if (load_c && !reset) begin
            bus.req_pop = grant;
        end
    end

    // Output register, round-robin pointer and forwarded-packet counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
            rr_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (load_c) begin
                data_q <= data_sel;
                rr_ptr <= (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
            end
            if (bus.popin && (state_q == FULL)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.pndng    = (state_q == FULL);
    assign bus.data_out = data_q;
    assign bus.pkt_cnt  = cnt_q;

endmodule

// File: tb/tb_mesh_port_arbiter.sv
// Purpose: self-checking bench for mesh_port_arbiter; directed scenarios followed by
//          random traffic, checked against a queue-based reference model.
module tb_mesh_port_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned P  = 40;
    localparam int unsigned CW = 8;

`ifdef MESH_ARB_BCAST_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic clk;
    logic reset;

    mesh_port_arbiter_if #(.NUM_REQ(N), .pckg_sz(P), .CNT_W(CW)) bus ();

    mesh_port_arbiter #(
        .NUM_REQ   (N),
        .pckg_sz   (P),
        .broadcast (8'hFF),
        .CNT_W     (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            total = 0;
    int            bad   = 0;
    logic [P-1:0]  heads [N];
    logic [P-1:0]  sb [$];
    int            m_ptr  = 0;
    bit            m_full = 1'b0;
    logic [CW-1:0] m_cnt  = '0;
    bit            in_reset = 1'b1;
    logic [N-1:0]  last_pop;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference winner: scan from the pointer, wrapping; broadcasts first when enabled.
    function automatic int model_pick(input logic [N-1:0] pend);
        logic [N-1:0] bc;
        logic [N-1:0] cand;
        bc = '0;
        for (int i = 0; i < N; i++) begin
            if (pend[i] && heads[i][P-1 -: 8] == 8'hFF) bc[i] = 1'b1;
        end
        cand = (PRIO && bc != '0) ? bc : pend;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (cand[i]) return i;
        end
        return -1;
    endfunction

    // One cycle of stimulus; predicted pops checked, loaded packets pushed to the scoreboard.
    task automatic step(input logic [N-1:0] pend, input logic pin);
        logic [N-1:0] exp_pop;
        int w;
        bit ld;
        bit was_full;
        @(negedge clk);
        for (int i = 0; i < N; i++) bus.req_data[i*P +: P] = heads[i];
        bus.req_pndng = pend;
        bus.popin     = pin;
        #2;
        w  = model_pick(pend);
        ld = (!m_full || pin) && (pend != '0);
        exp_pop = '0;
        if (ld && w >= 0) exp_pop[w] = 1'b1;
        last_pop = bus.req_pop;
        chk("req_pop", 64'(bus.req_pop), 64'(exp_pop));
        was_full = m_full;
        @(posedge clk);
        #1;
        if (was_full && pin) m_cnt = m_cnt + 1'b1;
        if (ld && w >= 0) begin
            sb.push_back(heads[w]);
            m_ptr  = (w + 1) % N;
            m_full = 1'b1;
        end else if (pin) begin
            m_full = 1'b0;
        end
    endtask

    // Asynchronous reset with requests pending and popin high: clears without a clock edge.
    task automatic do_reset();
        @(negedge clk);
        in_reset      = 1'b1;
        bus.req_pndng = '1;
        bus.popin     = 1'b1;
        #1 reset = 1'b1;
        #1;
        chk("rst_pndng",   64'(bus.pndng),    64'(0));
        chk("rst_data",    64'(bus.data_out), 64'(0));
        chk("rst_cnt",     64'(bus.pkt_cnt),  64'(0));
        chk("rst_req_pop", 64'(bus.req_pop),  64'(0));
        sb.delete();
        m_ptr  = 0;
        m_full = 1'b0;
        m_cnt  = '0;
        @(negedge clk);
        bus.req_pndng = '0;
        bus.popin     = 1'b0;
        reset         = 1'b0;
        #1 in_reset   = 1'b0;
    endtask

    // Monitor: whenever the register holds a packet it must match the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (!in_reset) begin
                chk("pndng", 64'(bus.pndng), 64'(sb.size() != 0));
                if (bus.pndng && sb.size() > 0) begin
                    chk("data_out", 64'(bus.data_out), 64'(sb[0]));
                    if (bus.popin) void'(sb.pop_front());
                end
                chk("pkt_cnt", 64'(bus.pkt_cnt), 64'(m_cnt));
            end
        end
    end

    initial begin
        reset         = 1'b1;
        bus.req_pndng = '0;
        bus.req_data  = '0;
        bus.popin     = 1'b0;
        for (int i = 0; i < N; i++) heads[i] = '0;
        do_reset();

        // Reset while holding a packet.
        heads[0] = 40'h12_3456_789A;
        step(4'b0001, 1'b0);
        step(4'b0000, 1'b0);
        chk("held_before_rst", 64'(bus.data_out), 64'h12_3456_789A);
        do_reset();

        // All pending, popin held: strict rotation at one packet per cycle.
        for (int i = 0; i < N; i++) heads[i] = P'(40'hA0 + i);
        for (int c = 0; c < 8; c++) step(4'b1111, 1'b1);
        step(4'b0000, 1'b1);
        chk("cnt_after_8", 64'(bus.pkt_cnt), 64'(8));

        // Backpressure: packet held stable, then drained and refilled on the same edge.
        heads[0] = 40'hB0;
        for (int c = 0; c < 5; c++) step(4'b0001, 1'b0);
        heads[0] = 40'hB1;
        step(4'b0001, 1'b1);
        chk("cnt_after_bp", 64'(bus.pkt_cnt), 64'(9));
        chk("refill_data", 64'(bus.data_out), 64'hB1);
        step(4'b0000, 1'b1);

        // Sparse requests and pointer wrap.
        do_reset();
        for (int i = 0; i < N; i++) heads[i] = P'(40'hC0 + i);
        step(4'b0100, 1'b1);
        step(4'b0101, 1'b1);
        chk("wrap_grant0", 64'(last_pop), 64'(4'b0001));
        step(4'b0101, 1'b1);
        chk("next_grant2", 64'(last_pop), 64'(4'b0100));
        step(4'b1000, 1'b1);
        chk("grant3", 64'(last_pop), 64'(4'b1000));
        step(4'b0001, 1'b1);
        chk("ptr_wrapped", 64'(last_pop), 64'(4'b0001));

        // popin while empty is ignored.
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        chk("empty_pndng", 64'(bus.pndng), 64'(0));

        // Broadcast head against a unicast head at the pointer.
        do_reset();
        heads[0] = {8'h05, 32'h0000_0000};
        heads[2] = {8'hFF, 32'h0000_0001};
        step(4'b0101, 1'b1);
        chk("bcast_first", 64'(last_pop), PRIO ? 64'(4'b0100) : 64'(4'b0001));
        step(4'b0000, 1'b1);

        // Random traffic, including occasional broadcast heads; long enough to wrap pkt_cnt.
        for (int c = 0; c < 700; c++) begin
            for (int i = 0; i < N; i++) begin
                heads[i] = P'({$urandom(), $urandom()});
                if ($urandom_range(0, 3) == 0) heads[i][P-1 -: 8] = 8'hFF;
            end
            step(N'($urandom()), ($urandom_range(0, 3) != 0));
        end
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        chk("drained", 64'(sb.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
